// File: rtl/ds_arb_pkg.sv
// Shared types and defaults for the CPU/debug data-memory arbiter.
// The state type is a plain vector so the encodings stay legacy-compatible.
package ds_arb_pkg;

  localparam int DS_ARB_AW_DEF         = 10;
  localparam int DS_ARB_DW_DEF         = 32;
  localparam int DS_ARB_STARVE_MAX_DEF = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_ARB   = 2'd0;
  localparam arb_state_t ST_FORCE = 2'd1;
  localparam arb_state_t ST_RESP  = 2'd2;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ds_arb_starve_cnt.sv
// Counts consecutive cycles a pending debug read loses to the CPU; hit marks the last allowed loss.
// Wraps to zero on the losing cycle that raises hit; clr has priority over inc.
module ds_arb_starve_cnt #(
  parameter int STARVE_MAX = ds_arb_pkg::DS_ARB_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  import ds_arb_pkg::*;

  localparam int CW = cnt_width(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  assign hit = (r_cnt == CW'(STARVE_MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= hit ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ds_arbiter.sv
// Data-memory arbiter: CPU has priority, a debug read is forced after STARVE_MAX losses (stalling the CPU).
// Debug latency 1 cycle uncontended, <= STARVE_MAX+1 contended; DS_ARB_STATS_EN adds conflict_cnt.
module ds_arbiter #(
  parameter int AW         = ds_arb_pkg::DS_ARB_AW_DEF,
  parameter int DW         = ds_arb_pkg::DS_ARB_DW_DEF,
  parameter int STARVE_MAX = ds_arb_pkg::DS_ARB_STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_valid,
  output logic          mem_str,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DS_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);
  import ds_arb_pkg::*;

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic [DW-1:0] r_dbg_rdata;

  logic w_in_arb;
  logic w_in_force;
  logic w_in_resp;
  logic w_dbg_serve;
  logic w_contend;
  logic w_hit;
  logic w_cnt_clr;

  assign w_in_arb    = (r_state == ST_ARB);
  assign w_in_force  = (r_state == ST_FORCE);
  assign w_in_resp   = (r_state == ST_RESP);
  assign w_dbg_serve = w_in_arb & dbg_req & ~cpu_req;
  assign w_contend   = w_in_arb & dbg_req & cpu_req;
  assign w_cnt_clr   = (w_in_arb & ~dbg_req) | w_dbg_serve | w_in_force;

  ds_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (w_contend),
    .clr (w_cnt_clr),
    .hit (w_hit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_dbg_serve) begin
          w_next = ST_RESP;
        end else if (w_contend && w_hit) begin
          w_next = ST_FORCE;
        end
      end
      ST_FORCE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_ARB;
      default:  w_next = ST_ARB;
    endcase
  end

  // The port only ever writes from the CPU side; a debug-addressed cycle never carries a store.
  assign mem_addr  = (w_dbg_serve | w_in_force) ? dbg_addr : cpu_addr;
  assign mem_str   = cpu_req & cpu_we & ~w_in_force;
  assign mem_wdata = cpu_wdata;
  assign cpu_rdata = mem_rdata;
  assign cpu_stall = w_in_force & cpu_req;
  assign dbg_valid = w_in_resp;
  assign dbg_rdata = r_dbg_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ARB;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_dbg_serve || w_in_force) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

`ifdef DS_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_cnt <= '0;
    end else if (cpu_stall && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_ds_arbiter.sv
// Bench for ds_arbiter: directed scenarios then random CPU/debug traffic against a transaction-level model.
module tb_ds_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_stall, dbg_valid, mem_str;
`ifdef DS_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  ds_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk (clk), .rst (rst),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata), .cpu_stall (cpu_stall),
    .dbg_req (dbg_req), .dbg_addr (dbg_addr), .dbg_rdata (dbg_rdata), .dbg_valid (dbg_valid),
    .mem_str (mem_str), .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
`ifdef DS_ARB_STATS_EN
    , .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory (asynchronous read, synchronous write) and the model's view of it.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_str) mem[mem_addr] <= mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  // Transaction model: losses = cycles the current debug read lost to the CPU.
  bit            m_resp;
  int            m_loss;
  logic [DW-1:0] m_dbg;
  int            m_conf;
  bit            last_valid;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_resp = 1'b0;
    m_loss = 0;
    m_dbg  = '0;
    m_conf = 0;
  endtask

  task automatic step(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input logic dreq, input logic [AW-1:0] daddr,
                      input bit mid_rst);
    bit            forced, dbg_now, served, e_str;
    logic [AW-1:0] e_addr;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_addr = daddr;
    forced  = !m_resp && (m_loss == SM);
    dbg_now = !m_resp && !forced && dreq && !creq;
    served  = creq && !forced;
    e_str   = served && cwe;
    e_addr  = (forced || dbg_now) ? daddr : caddr;
    @(negedge clk);
    chk("dbg_valid", DW'(dbg_valid), DW'(m_resp));
    chk("cpu_stall", DW'(cpu_stall), DW'(forced && creq));
    chk("mem_str",   DW'(mem_str),   DW'(e_str));
    chk("mem_addr",  DW'(mem_addr),  DW'(e_addr));
    chk("dbg_rdata", dbg_rdata, m_dbg);
    if (served && !cwe) chk("cpu_rdata", cpu_rdata, ref_mem[caddr]);
`ifdef DS_ARB_STATS_EN
    chk("conflict_cnt", DW'(conflict_cnt), DW'(m_conf));
`endif
    last_valid = m_resp;
    if (mid_rst) begin
      #1 rst = 1'b0;
      cpu_req = 1'b0; dbg_req = 1'b0;
      #1;
      model_reset();
      chk("rst_dbg_valid", DW'(dbg_valid), '0);
      chk("rst_cpu_stall", DW'(cpu_stall), '0);
      chk("rst_dbg_rdata", dbg_rdata, '0);
`ifdef DS_ARB_STATS_EN
      chk("rst_conflict_cnt", DW'(conflict_cnt), '0);
`endif
      #1 rst = 1'b1;
    end else begin
      if (forced || dbg_now) begin
        m_dbg  = ref_mem[daddr];
        m_loss = 0;
      end else if (!m_resp) begin
        m_loss = (dreq && creq) ? m_loss + 1 : 0;
      end
      m_resp = forced || dbg_now;
      if (e_str) ref_mem[caddr] = cwd;
      if (forced && creq && m_conf < 65535) m_conf++;
    end
    @(posedge clk);
    #1;
    if (creq && cwe && !mid_rst) chk("mem_word", mem[caddr], ref_mem[caddr]);
  endtask

  // Lose SM times to the CPU, then the forced slot (optionally with a store or retraction).
  task automatic contend_then_force(input logic [AW-1:0] daddr, input logic fwe,
                                    input logic fdreq, input bit mid_rst);
    for (int i = 0; i < SM; i++) step(1'b1, 1'b0, AW'($urandom), '0, 1'b1, daddr, 1'b0);
    step(1'b1, fwe, AW'('h20), 32'hCAFE_0001, fdreq, daddr, mid_rst);
  endtask

  initial begin
    logic [DW-1:0] v;
    bit            act;
    logic [AW-1:0] da;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 32'h1234_5678;
    ref_mem[5] = 32'h1234_5678;
    model_reset();
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    #2;
    chk("reset_dbg_valid", DW'(dbg_valid), '0);
    chk("reset_dbg_rdata", dbg_rdata, '0);
    chk("reset_cpu_stall", DW'(cpu_stall), '0);
    chk("reset_mem_str",   DW'(mem_str),   '0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Uncontended debug read of word 5.
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, AW'(5), 1'b0);
    chk("dbg_word5", dbg_rdata, 32'h1234_5678);

    // CPU store then load.
    step(1'b1, 1'b1, AW'('h10), 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, AW'('h10), '0, 1'b0, '0, 1'b0);
    chk("lw_0x10", cpu_rdata, 32'hDEAD_BEEF);

    // Starved debug read forced in cycle 4; the stalled store to 0x20 lands in the response cycle.
    contend_then_force(AW'('h33), 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, AW'('h20), 32'hCAFE_0001, 1'b0, AW'('h33), 1'b0);
    step(1'b1, 1'b0, AW'('h20), '0, 1'b0, '0, 1'b0);
    chk("lw_0x20", cpu_rdata, 32'hCAFE_0001);

    // Request retracted during the forced slot still completes.
    contend_then_force(AW'('h40), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, AW'('h40), 1'b0);
    chk("retract_valid", DW'(last_valid), 32'd1);

    // Reset in the forced slot aborts the transaction.
    contend_then_force(AW'('h41), 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);

    // Three forced slots with the CPU stalled.
    for (int k = 0; k < 3; k++) begin
      contend_then_force(AW'(k + 'h50), 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, AW'($urandom), '0, 1'b0, AW'(k + 'h50), 1'b0);
    end
`ifdef DS_ARB_STATS_EN
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("conflict_cnt_3", DW'(conflict_cnt), 32'd3);
`endif

    // Random traffic: the debug host holds its request until it sees the response.
    act = 1'b0;
    da  = '0;
    for (int n = 0; n < 600; n++) begin
      logic cr, cw, dr;
      bit   fnext;
      fnext = !m_resp && (m_loss == SM);
      cr = ($urandom_range(3) != 0);
      cw = 1'($urandom_range(1));
      if (!act && $urandom_range(2) == 0) begin
        act = 1'b1;
        da  = AW'($urandom);
      end
      dr = act;
      if (fnext && $urandom_range(1) == 1) dr = 1'b0;
      step(cr, cw, AW'($urandom), $urandom, dr, da, 1'b0);
      if (last_valid) act = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
